branch_predictor: RTL and testbench
===================================

// Module: branch_predictor
//
// PURPOSE
// - Fetch-side counterpart of the EX-stage branch condition evaluation: predicts branch
//   direction and target at IF, then is trained at EX with the resolved outcome (condi_suc).
// - Direct-mapped BTB with a 2-bit saturating direction counter per entry.
// - Counts resolved branches and mispredictions for performance reporting.
//
// PARAMETERS
// - IDX_BITS   6      log2 of entry count (64 entries); index = pc[IDX_BITS+1:2]
// - PC_W       32     PC and target width
// - CNT_INIT   2'b01  counter value loaded at reset (weakly not-taken)
//
// PORTS
// - clk              in   1         sole clock; all state updates on rising edge
// - rst              in   1         synchronous, active-high reset
// - pc_if            in   PC_W      PC of the instruction being fetched
// - pred_taken       out  1         IF prediction: redirect fetch to pred_target
// - pred_target      out  PC_W      predicted next PC
// - upd_valid        in   1         EX holds a resolved conditional branch (beq/bne/blez)
// - upd_pc           in   PC_W      PC of the resolved branch
// - upd_taken        in   1         resolved outcome (condi_suc)
// - upd_target       in   PC_W      resolved branch target
// - upd_pred_taken   in   1         prediction carried down the pipe for this branch
// - upd_pred_target  in   PC_W      predicted target carried down the pipe
// - mispredict       out  1         registered: previous-cycle update was mispredicted
// - branch_cnt       out  32        resolved branches since reset
// - mispred_cnt      out  32        mispredictions since reset
//
// BEHAVIOUR
// - Entry = {valid, tag = pc[PC_W-1:IDX_BITS+2], target, cnt[1:0]}.
// - Lookup combinational from registered state: hit = valid & tag match;
//   pred_taken = hit & cnt[1]; pred_target = pred_taken ? target : pc_if + 4.
// - Update when upd_valid & ~rst, at upd_pc's index:
//   - hit: cnt saturating +1 if taken (max 2'b11), -1 if not (min 2'b00);
//     target <= upd_target when taken.
//   - miss & taken: allocate/replace: valid=1, tag, target, cnt=2'b10.
//   - miss & not taken: no change.
// - Lookup and update to the same index in one cycle: lookup returns pre-update
//   contents; the update is visible from the next cycle. Only one update per cycle.
// - mispredict <= upd_valid & ((upd_taken != upd_pred_taken) |
//   (upd_taken & upd_pred_taken & (upd_target != upd_pred_target))); 0 when no update.
// - branch_cnt += 1 per upd_valid; mispred_cnt += 1 per misprediction; both wrap
//   2^32-1 -> 0.
// - Reset (synchronous, takes priority over a concurrent update, which is dropped):
//   all valid = 0, all cnt = CNT_INIT, targets/tags don't-care; mispredict = 0;
//   branch_cnt = mispred_cnt = 0. After reset pred_taken = 0, pred_target = pc_if + 4.
// - Reset asserted mid-stream: prediction state is lost; in-flight EX updates arriving
//   after reset deassertion are applied normally.
//
// STRUCTURE
// - Shared header mips_defines.vh: counter encodings SNT=2'b00, WNT=2'b01,
//   WT=2'b10, ST=2'b11; PC increment constant 4.
// - Sub-module sat_counter2: 2-bit saturating next-state function (cnt, taken -> cnt_nxt).
// - Table stored as per-field reg arrays; valid held in a flop vector so reset clears it.
//
// TESTING
// - Reset, pc_if=0x00400000 -> pred_taken=0, pred_target=0x00400004; counters 0.
// - Update pc=0x00400010 taken target=0x00400040, pred_taken=0 -> next cycle mispredict=1,
//   mispred_cnt=1; lookup of 0x00400010 -> pred_taken=1, target=0x00400040.
// - Same branch not-taken twice from 2'b10 -> cnt 00; third not-taken stays 00; pred_taken=0.
// - Alias 0x00400110 (same index, other tag) taken -> replaces entry; 0x00400010 now misses.
// - Lookup and update on same index in one cycle -> lookup returns old entry, new one next cycle.
// - rst asserted with upd_valid=1 -> update dropped, table invalid; branch_cnt preset
//   0xFFFFFFFF + one update -> wraps to 0.

Source files
------------

// File: rtl/branch_predictor_pkg.sv
// Shared constants for the fetch-side branch predictor: counter encodings,
// PC step, and the misprediction rule used when training at EX.
package branch_predictor_pkg;

  localparam logic [1:0] CNT_SNT = 2'b00;
  localparam logic [1:0] CNT_WNT = 2'b01;
  localparam logic [1:0] CNT_WT  = 2'b10;
  localparam logic [1:0] CNT_ST  = 2'b11;

  localparam int unsigned PC_INC = 4;

  // A taken branch predicted taken still counts as wrong if it went elsewhere.
  function automatic logic is_mispredict(input logic taken,
                                         input logic pred_taken,
                                         input logic target_match);
    return (taken != pred_taken) || (taken && pred_taken && !target_match);
  endfunction

endpackage

// File: rtl/sat_counter2.sv
// 2-bit saturating direction counter next-state function.
// Purely combinational; saturates at strongly-taken / strongly-not-taken.
module sat_counter2
  import branch_predictor_pkg::*;
(
  input  logic [1:0] i_cnt,
  input  logic       i_taken,
  output logic [1:0] o_cnt_nxt
);

  always_comb begin
    o_cnt_nxt = i_cnt;
    if (i_taken) begin
      if (i_cnt != CNT_ST) o_cnt_nxt = i_cnt + 2'd1;
    end else begin
      if (i_cnt != CNT_SNT) o_cnt_nxt = i_cnt - 2'd1;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit direction counters: combinational lookup at IF,
// single training update per cycle from EX, plus branch/mispredict statistics.
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int unsigned IDX_BITS = 6,
  parameter int unsigned PC_W     = 32,
  parameter logic [1:0]  CNT_INIT = CNT_WNT
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic [PC_W-1:0] i_pc_if,
  output logic            o_pred_taken,
  output logic [PC_W-1:0] o_pred_target,
  input  logic            i_upd_valid,
  input  logic [PC_W-1:0] i_upd_pc,
  input  logic            i_upd_taken,
  input  logic [PC_W-1:0] i_upd_target,
  input  logic            i_upd_pred_taken,
  input  logic [PC_W-1:0] i_upd_pred_target,
  output logic            o_mispredict,
  output logic [31:0]     o_branch_cnt,
  output logic [31:0]     o_mispred_cnt
);

  localparam int unsigned ENTRIES = 1 << IDX_BITS;
  localparam int unsigned TAG_W   = PC_W - IDX_BITS - 2;
  localparam logic [PC_W-1:0] W_PC_INC = PC_W'(PC_INC);

  logic [ENTRIES-1:0] r_valid;
  logic [TAG_W-1:0]   r_tag    [ENTRIES];
  logic [PC_W-1:0]    r_target [ENTRIES];
  logic [1:0]         r_cnt    [ENTRIES];

  logic               r_mispredict;
  logic [31:0]        r_branch_cnt;
  logic [31:0]        r_mispred_cnt;

  logic [IDX_BITS-1:0] w_if_idx;
  logic [TAG_W-1:0]    w_if_tag;
  logic                w_if_hit;
  logic [IDX_BITS-1:0] w_upd_idx;
  logic [TAG_W-1:0]    w_upd_tag;
  logic                w_upd_hit;
  logic [1:0]          w_cnt_nxt;
  logic                w_upd_mispred;
  logic                w_unused_pc_lsbs;

  assign w_if_idx  = i_pc_if[IDX_BITS+1:2];
  assign w_if_tag  = i_pc_if[PC_W-1:IDX_BITS+2];
  assign w_upd_idx = i_upd_pc[IDX_BITS+1:2];
  assign w_upd_tag = i_upd_pc[PC_W-1:IDX_BITS+2];
  assign w_unused_pc_lsbs = ^{i_pc_if[1:0], i_upd_pc[1:0]};

  // Lookup reads registered state only, so a same-cycle update is seen next cycle.
  assign w_if_hit      = r_valid[w_if_idx] && (r_tag[w_if_idx] == w_if_tag);
  assign o_pred_taken  = w_if_hit && r_cnt[w_if_idx][1];
  assign o_pred_target = o_pred_taken ? r_target[w_if_idx] : (i_pc_if + W_PC_INC);

  assign w_upd_hit = r_valid[w_upd_idx] && (r_tag[w_upd_idx] == w_upd_tag);

  sat_counter2 u_sat_counter2 (
    .i_cnt     (r_cnt[w_upd_idx]),
    .i_taken   (i_upd_taken),
    .o_cnt_nxt (w_cnt_nxt)
  );

  assign w_upd_mispred = is_mispredict(i_upd_taken, i_upd_pred_taken,
                                       i_upd_target == i_upd_pred_target);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_valid <= '0;
      for (int i = 0; i < ENTRIES; i++) r_cnt[i] <= CNT_INIT;
    end else if (i_upd_valid) begin
      if (w_upd_hit) begin
        r_cnt[w_upd_idx] <= w_cnt_nxt;
      end else if (i_upd_taken) begin
        r_valid[w_upd_idx] <= 1'b1;
        r_cnt[w_upd_idx]   <= CNT_WT;
      end
    end
  end

  // Tags and targets carry no reset; they are meaningless while valid is clear.
  always_ff @(posedge i_clk) begin
    if (!i_rst && i_upd_valid && i_upd_taken) begin
      r_target[w_upd_idx] <= i_upd_target;
      if (!w_upd_hit) r_tag[w_upd_idx] <= w_upd_tag;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_mispredict  <= 1'b0;
      r_branch_cnt  <= '0;
      r_mispred_cnt <= '0;
    end else begin
      r_mispredict <= i_upd_valid && w_upd_mispred;
      if (i_upd_valid) begin
        r_branch_cnt <= r_branch_cnt + 32'd1;
        if (w_upd_mispred) r_mispred_cnt <= r_mispred_cnt + 32'd1;
      end
    end
  end

  assign o_mispredict  = r_mispredict;
  assign o_branch_cnt  = r_branch_cnt;
  assign o_mispred_cnt = r_mispred_cnt;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: stimulus pushes per-cycle expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_if;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_pred_taken;
  logic [31:0] upd_pred_target;
  logic        mispredict;
  logic [31:0] branch_cnt;
  logic [31:0] mispred_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  typedef struct {
    int          cyc;
    string       name;
    bit          chk_pred;
    logic        ptk;
    logic [31:0] ptgt;
    bit          chk_stat;
    logic        misp;
    logic [31:0] bcnt;
    logic [31:0] mcnt;
  } exp_t;

  exp_t q[$];
  exp_t e;

  branch_predictor dut (
    .i_clk             (clk),
    .i_rst             (rst),
    .i_pc_if           (pc_if),
    .o_pred_taken      (pred_taken),
    .o_pred_target     (pred_target),
    .i_upd_valid       (upd_valid),
    .i_upd_pc          (upd_pc),
    .i_upd_taken       (upd_taken),
    .i_upd_target      (upd_target),
    .i_upd_pred_taken  (upd_pred_taken),
    .i_upd_pred_target (upd_pred_target),
    .o_mispredict      (mispredict),
    .o_branch_cnt      (branch_cnt),
    .o_mispred_cnt     (mispred_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input string what,
                     input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s.%s: got %h expected %h", nm, what, act, exp);
    end
  endtask

  always @(negedge clk) begin
    while (q.size() != 0 && q[0].cyc <= cyc) begin
      e = q.pop_front();
      if (e.cyc != cyc) begin
        n_tests++;
        n_fail++;
        $display("FAIL %s: expectation for cycle %0d missed at cycle %0d", e.name, e.cyc, cyc);
      end else begin
        if (e.chk_pred) begin
          chk(e.name, "pred_taken", {31'd0, pred_taken}, {31'd0, e.ptk});
          chk(e.name, "pred_target", pred_target, e.ptgt);
        end
        if (e.chk_stat) begin
          chk(e.name, "mispredict", {31'd0, mispredict}, {31'd0, e.misp});
          chk(e.name, "branch_cnt", branch_cnt, e.bcnt);
          chk(e.name, "mispred_cnt", mispred_cnt, e.mcnt);
        end
      end
    end
  end

  // Drive one cycle's inputs, queue what the outputs must show this cycle, advance.
  task automatic step(input logic r, input logic [31:0] pc,
                      input logic uv, input logic [31:0] upc, input logic ut,
                      input logic [31:0] utgt, input logic upt, input logic [31:0] uptgt,
                      input string nm,
                      input bit cp, input logic ptk, input logic [31:0] ptgt,
                      input bit cs, input logic misp, input logic [31:0] bc,
                      input logic [31:0] mc);
    exp_t x;
    rst = r; pc_if = pc;
    upd_valid = uv; upd_pc = upc; upd_taken = ut; upd_target = utgt;
    upd_pred_taken = upt; upd_pred_target = uptgt;
    x.cyc = cyc; x.name = nm;
    x.chk_pred = cp; x.ptk = ptk; x.ptgt = ptgt;
    x.chk_stat = cs; x.misp = misp; x.bcnt = bc; x.mcnt = mc;
    q.push_back(x);
    @(posedge clk);
    #1;
  endtask

  localparam logic [31:0] A10  = 32'h0040_0010;
  localparam logic [31:0] A110 = 32'h0040_0110;
  localparam logic [31:0] A30  = 32'h0040_0030;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; pc_if = '0; upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0;
    upd_target = '0; upd_pred_taken = 1'b0; upd_pred_target = '0;
    repeat (2) @(posedge clk);
    #1;
    //   rst pc_if        uv upd_pc         t  target        pt ptarget      name          cp tk tgt            cs m  bc     mc
    step(0, 32'h0040_0000, 0, 0,            0, 0,            0, 0,            "reset",      1, 0, 32'h0040_0004, 1, 0, 0,  0);
    step(0, A10,           1, A10,          1, 32'h0040_0040, 0, 32'h0040_0014, "alloc_same", 1, 0, 32'h0040_0014, 1, 0, 0,  0);
    step(0, A10,           0, 0,            0, 0,            0, 0,            "alloc_hit",  1, 1, 32'h0040_0040, 1, 1, 1,  1);
    step(0, A10,           1, A10,          0, 32'h0040_0044, 1, 32'h0040_0040, "nt1",        1, 1, 32'h0040_0040, 1, 0, 1,  1);
    step(0, A10,           1, A10,          0, 32'h0040_0044, 0, 32'h0040_0014, "nt2",        1, 0, 32'h0040_0014, 1, 1, 2,  2);
    step(0, A10,           1, A10,          0, 32'h0040_0044, 0, 32'h0040_0014, "nt3",        1, 0, 32'h0040_0014, 1, 0, 3,  2);
    step(0, A10,           0, 0,            0, 0,            0, 0,            "sat_low",    1, 0, 32'h0040_0014, 1, 0, 4,  2);
    step(0, A10,           1, A10,          1, 32'h0040_0040, 0, 32'h0040_0014, "tk1",        1, 0, 32'h0040_0014, 1, 0, 4,  2);
    step(0, A10,           1, A10,          1, 32'h0040_0040, 0, 32'h0040_0014, "tk2",        1, 0, 32'h0040_0014, 1, 1, 5,  3);
    step(0, A10,           0, 0,            0, 0,            0, 0,            "wt_again",   1, 1, 32'h0040_0040, 1, 1, 6,  4);
    step(0, A10,           1, A10,          1, 32'h0040_0080, 1, 32'h0040_0040, "tgt_chg",    1, 1, 32'h0040_0040, 1, 0, 6,  4);
    step(0, A10,           1, A10,          1, 32'h0040_0080, 1, 32'h0040_0080, "tgt_ok",     1, 1, 32'h0040_0080, 1, 1, 7,  5);
    step(0, A10,           1, A110,         1, 32'h0040_0200, 0, 32'h0040_0114, "alias_upd",  1, 1, 32'h0040_0080, 1, 0, 8,  5);
    step(0, A10,           0, 0,            0, 0,            0, 0,            "alias_miss", 1, 0, 32'h0040_0014, 1, 1, 9,  6);
    step(0, A110,          1, 32'h0040_0020, 0, 32'h0040_0400, 0, 32'h0040_0024, "alias_hit",  1, 1, 32'h0040_0200, 1, 0, 9,  6);
    step(0, 32'h0040_0020, 0, 0,            0, 0,            0, 0,            "nt_noalloc", 1, 0, 32'h0040_0024, 1, 0, 10, 6);
    step(1, A110,          1, A30,          1, 32'h0040_0300, 0, 32'h0040_0034, "rst_upd",    1, 1, 32'h0040_0200, 1, 0, 10, 6);
    step(0, A110,          0, 0,            0, 0,            0, 0,            "post_rst",   1, 0, 32'h0040_0114, 1, 0, 0,  0);
    step(0, A30,           1, A30,          1, 32'h0040_0300, 0, 32'h0040_0034, "dropped",    1, 0, 32'h0040_0034, 1, 0, 0,  0);
    step(0, A30,           0, 0,            0, 0,            0, 0,            "applied",    1, 1, 32'h0040_0300, 1, 1, 1,  1);
    force dut.r_branch_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.r_branch_cnt;
    step(0, A30,           1, A30,          1, 32'h0040_0300, 1, 32'h0040_0300, "wrap_upd",   1, 1, 32'h0040_0300, 0, 0, 0,  0);
    step(0, A30,           0, 0,            0, 0,            0, 0,            "wrap",       1, 1, 32'h0040_0300, 1, 0, 0,  1);
    repeat (3) @(posedge clk);
    if (q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d expectations never checked", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
